// File: rtl/rf_wr_pkg.sv
// rf_wr_pkg: shared widths and FSM state type for the register-file write sequencer
package rf_wr_pkg;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int SEL_W  = 3;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} rf_wr_state_t;
endpackage

// File: rtl/rf_wr_sequencer_prio_enc8.sv
// prio_enc8: index of the lowest set bit of a register mask, plus an any-set flag
module prio_enc8
    import rf_wr_pkg::*;
(
    input  logic [NREG-1:0]  m,
    output logic [SEL_W-1:0] idx,
    output logic             any_set
);
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (m[i]) idx = SEL_W'(i);
    end
    assign any_set = |m;
endmodule

// File: rtl/rf_wr_sequencer.sv
// rf_wr_sequencer: arbitrates single writes vs load-multiple bursts onto one RF write port (option: RF_WR_PC_GUARD_EN)
module rf_wr_sequencer
    import rf_wr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_valid,
    output logic              sw_ready,
    input  logic [SEL_W-1:0]  sw_sel,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              bm_start,
    output logic              bm_ready,
    input  logic [NREG-1:0]   bm_mask,
    input  logic              bm_dvalid,
    output logic              bm_dready,
    input  logic [DATA_W-1:0] bm_data,
    output logic              rf_we,
    output logic [SEL_W-1:0]  rf_sel,
    output logic [DATA_W-1:0] rf_data,
    output logic              busy,
`ifdef RF_WR_PC_GUARD_EN
    output logic              pc_wr,
`endif
    output logic              bm_done
);
    rf_wr_state_t      state;
    logic [NREG-1:0]   mask;
    logic [NREG-1:0]   nxt_mask;
    logic [SEL_W-1:0]  cur;
    logic              any_set;
    logic              sw_acc, bm_acc, beat, last;

    prio_enc8 u_enc (.m(mask), .idx(cur), .any_set(any_set));

    assign sw_ready  = state == ST_IDLE;
    assign bm_ready  = state == ST_IDLE && !sw_valid;
    assign bm_dready = state == ST_BURST;
    assign busy      = state == ST_BURST;
    assign sw_acc    = sw_valid && sw_ready;
    assign bm_acc    = bm_start && bm_ready;
    assign beat      = bm_dvalid && bm_dready;
    assign nxt_mask  = mask & ~(NREG'(1) << cur);
`ifdef RF_WR_PC_GUARD_EN
    // a write to the PC ends the burst; later mask bits are discarded
    assign last  = nxt_mask == '0 || cur == SEL_W'(NREG - 1);
    assign pc_wr = rf_we && rf_sel == SEL_W'(NREG - 1);
`else
    assign last  = nxt_mask == '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            mask    <= '0;
            rf_we   <= 1'b0;
            rf_sel  <= '0;
            rf_data <= '0;
            bm_done <= 1'b0;
        end else begin
            rf_we   <= sw_acc || beat;
            bm_done <= (bm_acc && bm_mask == '0) || (beat && last);
            if (sw_acc) begin
                rf_sel  <= sw_sel;
                rf_data <= sw_data;
            end else if (beat) begin
                rf_sel  <= cur;
                rf_data <= bm_data;
            end
            if (bm_acc && bm_mask != '0) begin
                state <= ST_BURST;
                mask  <= bm_mask;
            end else if (beat) begin
                state <= last ? ST_IDLE : ST_BURST;
                mask  <= last ? '0 : nxt_mask;
            end
        end
    end
endmodule

// File: tb/tb_rf_wr_sequencer.sv
// tb_rf_wr_sequencer: directed self-checking bench for rf_wr_sequencer
module tb_rf_wr_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sw_valid = 1'b0, sw_ready;
    logic [2:0]  sw_sel = '0;
    logic [15:0] sw_data = '0;
    logic        bm_start = 1'b0, bm_ready;
    logic [7:0]  bm_mask = '0;
    logic        bm_dvalid = 1'b0, bm_dready;
    logic [15:0] bm_data = '0;
    logic        rf_we, busy, bm_done;
    logic [2:0]  rf_sel;
    logic [15:0] rf_data;
`ifdef RF_WR_PC_GUARD_EN
    logic        pc_wr;
`endif
    int n_checks = 0;
    int n_fail = 0;

    rf_wr_sequencer dut (
        .clk(clk), .reset(reset),
        .sw_valid(sw_valid), .sw_ready(sw_ready), .sw_sel(sw_sel), .sw_data(sw_data),
        .bm_start(bm_start), .bm_ready(bm_ready), .bm_mask(bm_mask),
        .bm_dvalid(bm_dvalid), .bm_dready(bm_dready), .bm_data(bm_data),
        .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data), .busy(busy),
`ifdef RF_WR_PC_GUARD_EN
        .pc_wr(pc_wr),
`endif
        .bm_done(bm_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", rf_we); end
        n_checks++; if (rf_sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", rf_sel); end
        n_checks++; if (rf_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", rf_data); end
        n_checks++; if (busy !== 1'b0 || bm_done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", busy, bm_done); end
        n_checks++; if ({sw_ready, bm_ready, bm_dready} !== 3'b110) begin n_fail++; $display("FAIL reset_ready got %b exp 110", {sw_ready, bm_ready, bm_dready}); end
    endtask

    task automatic test_single();
        sw_valid = 1'b1; sw_sel = 3'd3; sw_data = 16'hBEEF;
        step();
        sw_valid = 1'b0;
        n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 3'd3, 16'hBEEF}) begin n_fail++; $display("FAIL single_write got we=%b sel=%0d data=%h exp we=1 sel=3 data=beef", rf_we, rf_sel, rf_data); end
        step();
        n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b0, 3'd3, 16'hBEEF}) begin n_fail++; $display("FAIL single_hold got we=%b sel=%0d data=%h exp we=0 sel=3 data=beef", rf_we, rf_sel, rf_data); end
    endtask

    task automatic test_burst();
        logic [2:0]  exp_sel [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [15:0] dat [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        bm_start = 1'b1; bm_mask = 8'b1010_0101;
        step();
        bm_start = 1'b0;
        n_checks++; if ({busy, bm_dready, sw_ready, rf_we} !== 4'b1100) begin n_fail++; $display("FAIL burst_enter got busy/dready/swr/we=%b exp 1100", {busy, bm_dready, sw_ready, rf_we}); end
        for (int i = 0; i < 4; i++) begin
            bm_dvalid = 1'b1; bm_data = dat[i];
            step();
            n_checks++; if ({rf_we, rf_sel, rf_data, bm_done} !== {1'b1, exp_sel[i], dat[i], i == 3}) begin n_fail++; $display("FAIL burst_beat%0d got we=%b sel=%0d data=%h done=%b exp sel=%0d data=%h done=%b", i, rf_we, rf_sel, rf_data, bm_done, exp_sel[i], dat[i], i == 3); end
        end
        bm_dvalid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_exit got busy=%b exp 0", busy); end
        step();
        n_checks++; if ({rf_we, bm_done} !== 2'b00) begin n_fail++; $display("FAIL burst_after got we/done=%b exp 00", {rf_we, bm_done}); end
    endtask

    task automatic test_priority();
        sw_valid = 1'b1; sw_sel = 3'd1; sw_data = 16'h1111;
        bm_start = 1'b1; bm_mask = 8'h01;
        #1;
        n_checks++; if ({sw_ready, bm_ready} !== 2'b10) begin n_fail++; $display("FAIL prio_ready got swr/bmr=%b exp 10", {sw_ready, bm_ready}); end
        step();
        sw_valid = 1'b0;
        #1;
        n_checks++; if ({rf_we, rf_sel, busy, bm_ready} !== {1'b1, 3'd1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL prio_single got we=%b sel=%0d busy=%b bmr=%b exp 1 1 0 1", rf_we, rf_sel, busy, bm_ready); end
        step();
        bm_start = 1'b0;
        n_checks++; if ({busy, rf_we} !== 2'b10) begin n_fail++; $display("FAIL prio_burst got busy/we=%b exp 10", {busy, rf_we}); end
        bm_dvalid = 1'b1; bm_data = 16'h2222;
        step();
        bm_dvalid = 1'b0;
        n_checks++; if ({rf_we, rf_sel, rf_data, bm_done} !== {1'b1, 3'd0, 16'h2222, 1'b1}) begin n_fail++; $display("FAIL prio_beat got we=%b sel=%0d data=%h done=%b exp 1 0 2222 1", rf_we, rf_sel, rf_data, bm_done); end
    endtask

    task automatic test_gapped();
        logic [2:0] exp_sel [2] = '{3'd1, 3'd2};
        bm_start = 1'b1; bm_mask = 8'h06;
        step();
        bm_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < 2; g++) begin
                sw_valid = 1'b1; sw_sel = 3'd4; sw_data = 16'hDEAD;
                step();
                n_checks++; if ({rf_we, sw_ready, busy} !== 3'b001) begin n_fail++; $display("FAIL gap_b%0d_g%0d got we/swr/busy=%b exp 001", b, g, {rf_we, sw_ready, busy}); end
            end
            sw_valid = 1'b0;
            bm_dvalid = 1'b1; bm_data = 16'h3300 + 16'(b);
            step();
            bm_dvalid = 1'b0;
            n_checks++; if ({rf_we, rf_sel, rf_data, bm_done} !== {1'b1, exp_sel[b], 16'h3300 + 16'(b), b == 1}) begin n_fail++; $display("FAIL gap_beat%0d got we=%b sel=%0d data=%h done=%b exp sel=%0d", b, rf_we, rf_sel, rf_data, bm_done, exp_sel[b]); end
        end
    endtask

    task automatic test_zero_mask();
        bm_start = 1'b1; bm_mask = 8'h00;
        step();
        bm_start = 1'b0;
        n_checks++; if ({rf_we, bm_done, busy, bm_ready} !== 4'b0101) begin n_fail++; $display("FAIL zero_mask got we/done/busy/bmr=%b exp 0101", {rf_we, bm_done, busy, bm_ready}); end
        step();
        n_checks++; if ({rf_we, bm_done} !== 2'b00) begin n_fail++; $display("FAIL zero_mask_after got we/done=%b exp 00", {rf_we, bm_done}); end
    endtask

    task automatic test_reset_mid();
        bm_start = 1'b1; bm_mask = 8'h70;
        step();
        bm_start = 1'b0;
        bm_dvalid = 1'b1; bm_data = 16'h5555;
        step();
        bm_dvalid = 1'b0;
        n_checks++; if ({rf_we, rf_sel, busy} !== {1'b1, 3'd4, 1'b1}) begin n_fail++; $display("FAIL rst_mid_beat got we=%b sel=%0d busy=%b exp 1 4 1", rf_we, rf_sel, busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if ({rf_we, rf_sel, rf_data, busy, bm_done, sw_ready} !== {1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rst_mid got we=%b sel=%0d data=%h busy=%b done=%b swr=%b exp all 0, swr=1", rf_we, rf_sel, rf_data, busy, bm_done, sw_ready); end
        step();
        n_checks++; if ({rf_we, bm_done, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_after got we/done/busy=%b exp 000", {rf_we, bm_done, busy}); end
    endtask

    task automatic test_back_to_back();
        bm_start = 1'b1; bm_mask = 8'h01;
        step();
        bm_start = 1'b0;
        bm_dvalid = 1'b1; bm_data = 16'h7777;
        step();
        bm_dvalid = 1'b0;
        n_checks++; if ({rf_we, rf_sel, bm_done, sw_ready} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL b2b_last got we=%b sel=%0d done=%b swr=%b exp 1 0 1 1", rf_we, rf_sel, bm_done, sw_ready); end
        sw_valid = 1'b1; sw_sel = 3'd6; sw_data = 16'h6666;
        step();
        sw_sel = 3'd5; sw_data = 16'h6565;
        n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 3'd6, 16'h6666}) begin n_fail++; $display("FAIL b2b_single0 got we=%b sel=%0d data=%h exp 1 6 6666", rf_we, rf_sel, rf_data); end
        step();
        sw_valid = 1'b0;
        n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 3'd5, 16'h6565}) begin n_fail++; $display("FAIL b2b_single1 got we=%b sel=%0d data=%h exp 1 5 6565", rf_we, rf_sel, rf_data); end
        step();
    endtask

`ifdef RF_WR_PC_GUARD_EN
    task automatic test_pc_guard();
        logic [2:0] exp_sel [3] = '{3'd0, 3'd6, 3'd7};
        bm_start = 1'b1; bm_mask = 8'hC1;
        step();
        bm_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bm_dvalid = 1'b1; bm_data = 16'hC000 + 16'(i);
            step();
            n_checks++; if ({rf_we, rf_sel, bm_done, pc_wr} !== {1'b1, exp_sel[i], i == 2, i == 2}) begin n_fail++; $display("FAIL pc_beat%0d got we=%b sel=%0d done=%b pc=%b exp sel=%0d", i, rf_we, rf_sel, bm_done, pc_wr, exp_sel[i]); end
        end
        bm_dvalid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pc_exit got busy=%b exp 0", busy); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_priority();
        test_gapped();
        test_zero_mask();
        test_reset_mid();
        test_back_to_back();
`ifdef RF_WR_PC_GUARD_EN
        test_pc_guard();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
